// File: rtl/wallace_mult_arbiter.sv
// rtl/wallace_mult_arbiter.sv - round-robin sharing of one pipelined 8x8 multiplier
//
// Purpose: N_REQ requesters compete for one external pipelined multiplier.
//   A round-robin arbiter issues at most one operand pair per cycle. A tag pipe
//   carries the requester id through the multiplier latency. Results return in
//   issue order through a credit-protected response FIFO.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         packed unsigned 8-bit operands, requester i at [8i+7:8i]
//   mul_a, mul_b         registered operands to the external multiplier
//   mul_product          product from the multiplier output register
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_id     product and requester index at the FIFO head
//   perf_issue_cnt       (MULT_ARB_PERF_EN) saturating issue counter
//   perf_stall_cnt       (MULT_ARB_PERF_EN) saturating no-credit stall counter
// Optional feature macro: MULT_ARB_PERF_EN
module wallace_mult_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = 3,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [8*N_REQ-1:0]         req_a,
  input  logic [8*N_REQ-1:0]         req_b,
  output logic [7:0]                 mul_a,
  output logic [7:0]                 mul_b,
  input  logic [15:0]                mul_product,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [31:0]                perf_issue_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One tag register per edge between issue and the cycle in which the tail
  // lines up with mul_product.
  localparam int STG   = MULT_LATENCY + 1;
  localparam int OCC_W = $clog2(RESP_DEPTH + MULT_LATENCY + 3) + 1;

  logic [ID_W-1:0]  r_rr_ptr;
  logic [7:0]       r_mul_a;
  logic [7:0]       r_mul_b;
  logic [STG-1:0]   r_tag_v;
  logic [ID_W-1:0]  r_tag_id [STG];

  logic [15:0]      r_mem_d  [RESP_DEPTH];
  logic [ID_W-1:0]  r_mem_id [RESP_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_any;
  logic [ID_W-1:0]  w_grant;
  logic [OCC_W-1:0] w_inflight;
  logic [OCC_W-1:0] w_used;
  logic             w_credit_ok;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [N_REQ-1:0] w_ready;

  // Scan from rr_ptr upward; iterating downward lets the lowest offset win.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_any   = 1'b1;
        w_grant = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  // Every valid tag will land in the FIFO, so all of them consume credit.
  always_comb begin
    w_inflight = '0;
    for (int s = 0; s < STG; s++) begin
      w_inflight = w_inflight + OCC_W'(r_tag_v[s]);
    end
  end

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_tag_v[STG-1];
  assign w_used    = OCC_W'(r_count) + w_inflight;
  // A pop this cycle frees its entry at the same edge a new issue enters.
  assign w_credit_ok = (w_used < (OCC_W'(RESP_DEPTH) + OCC_W'(w_pop)));
  assign w_issue     = w_any & w_credit_ok & rst;

  always_comb begin
    w_ready = '0;
    if (w_issue) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_data  = r_mem_d[r_rd_ptr];
  assign rsp_id    = r_mem_id[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_tag_v  <= '0;
      for (int s = 0; s < STG; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_v     <= {r_tag_v[STG-2:0], w_issue};
      r_tag_id[0] <= w_grant;
      for (int s = 1; s < STG; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
      if (w_issue) begin
        r_mul_a  <= req_a[8*w_grant +: 8];
        r_mul_b  <= req_b[8*w_grant +: 8];
        r_rr_ptr <= (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
      end else begin
        r_mul_a  <= '0;
        r_mul_b  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int e = 0; e < RESP_DEPTH; e++) begin
        r_mem_d[e]  <= '0;
        r_mem_id[e] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_d[r_wr_ptr]  <= mul_product;
        r_mem_id[r_wr_ptr] <= r_tag_id[STG-1];
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (r_count == CNT_W'(RESP_DEPTH))));
`endif

`ifdef MULT_ARB_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (|req_valid) & ~w_credit_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue && (r_perf_issue != 32'hFFFF_FFFF)) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end
      if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = r_perf_issue;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// tb/tb_wallace_mult_arbiter.sv - self-checking bench for wallace_mult_arbiter
module tb_wallace_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
`ifdef MULT_ARB_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Operands 17*13, 99*101, 150*250, 200*3 for requesters 0..3
  logic [15:0] prod_rr [4] = '{16'd221, 16'd9999, 16'd37500, 16'd600};
  logic [15:0] prod_edge [4] = '{16'd0, 16'd1, 16'd256, 16'd56};

  // Three-register multiplier model: product visible after the 3rd edge.
  logic [15:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= mul_a * mul_b;
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_product = p3;

  always #5 clk = ~clk;

  wallace_mult_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
`ifdef MULT_ARB_PERF_EN
    .rsp_id      (rsp_id),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .rsp_id      (rsp_id)
`endif
  );

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic set_rr_operands();
    req_a = {8'd200, 8'd150, 8'd99, 8'd17};
    req_b = {8'd3, 8'd250, 8'd101, 8'd13};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b expected 0000 0", req_ready, rsp_valid);
    end
    checks++;
    if (mul_a !== 8'd0 || mul_b !== 8'd0 || rsp_data !== 16'd0 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_data: mul_a=%0d mul_b=%0d rsp_data=%0d rsp_id=%0d expected all 0",
               mul_a, mul_b, rsp_data, rsp_id);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    req_a = '0;
    req_b = '0;
    req_a[7:0] = 8'd255;
    req_b[7:0] = 8'd255;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (mul_a !== 8'd255 || mul_b !== 8'd255) begin
      failures++;
      $display("FAIL single_operands: mul_a=%0d mul_b=%0d expected 255 255", mul_a, mul_b);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== (k == 4)) begin
        failures++;
        $display("FAIL single_latency: edge %0d rsp_valid=%b expected %b", k, rsp_valid, (k == 4));
      end
    end
    checks++;
    if (rsp_data !== 16'd65025 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL single_result: data=%0d id=%0d expected 65025 0", rsp_data, rsp_id);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int acc = 0;
    int got = 0;
    logic [3:0] exp_r;
    do_reset();
    set_rr_operands();
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      req_valid = (acc < 8) ? 4'hF : 4'h0;
      #1;
      if (|req_ready) begin
        exp_r = 4'(1 << (acc % 4));
        checks++;
        if (req_ready !== exp_r) begin
          failures++;
          $display("FAIL rr_grant: accept %0d req_ready=%b expected %b", acc, req_ready, exp_r);
        end
        acc++;
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (rsp_id !== 2'(got % 4) || rsp_data !== prod_rr[got % 4]) begin
          failures++;
          $display("FAIL rr_rsp: #%0d id=%0d data=%0d expected id=%0d data=%0d",
                   got, rsp_id, rsp_data, got % 4, prod_rr[got % 4]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    checks++;
    if (acc != 8 || got != 8) begin
      failures++;
      $display("FAIL rr_count: accepts=%0d responses=%0d expected 8 8", acc, got);
    end
  endtask

  task automatic test_back_pressure();
    int acc = 0;
    int got = 0;
    logic [3:0] exp_r;
    do_reset();
    set_rr_operands();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (|req_ready) acc++;
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (acc != 4 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL bp_fill: accepts=%0d req_ready=%b expected 4 0000", acc, req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== prod_rr[0]) begin
      failures++;
      $display("FAIL bp_head: valid=%b id=%0d data=%0d expected 1 0 %0d",
               rsp_valid, rsp_id, rsp_data, prod_rr[0]);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_r = 4'(1 << (acc % 4));
      checks++;
      if (req_ready !== exp_r) begin
        failures++;
        $display("FAIL bp_refill: pop %0d req_ready=%b expected %b", c, req_ready, exp_r);
      end
      if (|req_ready) acc++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(got % 4) || rsp_data !== prod_rr[got % 4]) begin
        failures++;
        $display("FAIL bp_rsp: #%0d valid=%b id=%0d data=%0d expected 1 %0d %0d",
                 got, rsp_valid, rsp_id, rsp_data, got % 4, prod_rr[got % 4]);
      end
      if (rsp_valid) got++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== 2'(got % 4) || rsp_data !== prod_rr[got % 4]) begin
          failures++;
          $display("FAIL bp_drain: #%0d id=%0d data=%0d expected %0d %0d",
                   got, rsp_id, rsp_data, got % 4, prod_rr[got % 4]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (acc != 8 || got != 8) begin
      failures++;
      $display("FAIL bp_count: accepts=%0d responses=%0d expected 8 8", acc, got);
    end
  endtask

  task automatic test_edge_operands();
    int got = 0;
    logic [3:0] w;
    do_reset();
    req_a = {8'd7, 8'd128, 8'd1, 8'd0};
    req_b = {8'd8, 8'd2, 8'd1, 8'd200};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      #1;
      w = req_ready;
      if (rsp_valid) begin
        checks++;
        if (rsp_id !== 2'(got) || rsp_data !== prod_edge[got]) begin
          failures++;
          $display("FAIL edge_rsp: #%0d id=%0d data=%0d expected %0d %0d",
                   got, rsp_id, rsp_data, got, prod_edge[got]);
        end
        got++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~w;
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL edge_count: responses=%0d expected 4", got);
    end
  endtask

  task automatic test_reset_midflight();
    int edges = 0;
    do_reset();
    set_rr_operands();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== prod_rr[0]) begin
      failures++;
      $display("FAIL mid_preload: valid=%b data=%0d expected 1 %0d", rsp_valid, rsp_data, prod_rr[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'd0 || rsp_id !== 2'd0 || mul_a !== 8'd0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b data=%0d id=%0d mul_a=%0d ready=%b expected 0 0 0 0 0000",
               rsp_valid, rsp_data, rsp_id, mul_a, req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale: cycle %0d rsp_valid=%b expected 0", c, rsp_valid);
      end
    end
    req_a[23:16] = 8'd13;
    req_b[23:16] = 8'd11;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL mid_ready: req_ready=%b expected 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    while (edges < 10 && rsp_valid !== 1'b1) begin
      @(posedge clk); #1;
      edges++;
    end
    checks++;
    if (edges != 4 || rsp_data !== 16'd143 || rsp_id !== 2'd2) begin
      failures++;
      $display("FAIL mid_result: edges=%0d data=%0d id=%0d expected 4 143 2", edges, rsp_data, rsp_id);
    end
    @(posedge clk); #1;
  endtask

`ifdef MULT_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    req_a = '0;
    req_b = '0;
    req_a[7:0] = 8'd3;
    req_b[7:0] = 8'd5;
    #1;
    checks++;
    if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: issue=%0d stall=%0d expected 0 0", perf_issue_cnt, perf_stall_cnt);
    end
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      req_valid = 4'b0001;
      @(posedge clk); #1;
      req_valid = '0;
      repeat (6) @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (9) @(posedge clk);
    #1;
    req_valid = '0;
    checks++;
    if (perf_issue_cnt !== 32'd10 || perf_stall_cnt !== 32'd5) begin
      failures++;
      $display("FAIL perf_counts: issue=%0d stall=%0d expected 10 5", perf_issue_cnt, perf_stall_cnt);
    end
    rsp_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_edge_operands();
    test_reset_midflight();
`ifdef MULT_ARB_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
